// File: rtl/fpu_operand_loader.sv
// Operand-side sequencer for the FPU: collects 32-bit words into two 64-bit
// operand registers and pulses cyc0_rdy/cyc1_rdy as each operand completes.
//   state | meaning
//   IDLE  | waiting for op_valid
//   LOAD0 | collecting operand 0 words
//   LOAD1 | collecting operand 1 words
//   EXEC  | operands held until exec_done
module fpu_operand_loader (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        op_valid,
  input  logic [1:0]  op_prec,
  input  logic        op_two,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_rdy,
  input  logic        exec_done,
  input  logic        kill,
  output logic        cyc0_rdy,
  output logic        cyc1_rdy,
  output logic [2:0]  cyc0_type,
  output logic [63:0] op0,
  output logic [63:0] op1,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD0, S_LOAD1, S_EXEC} state_t;

  state_t      state, state_nx;
  logic [1:0]  prec;
  logic        two;
  logic        cnt;
  logic        wide;
  logic        accept;
  logic        xfer;
  logic        last;

  function automatic logic [2:0] type_of(input logic [1:0] p, input logic t);
    case (p)
      2'd0:    type_of = 3'd1;
      2'd1:    type_of = t ? 3'd0 : 3'd3;
      2'd2:    type_of = 3'd4;
      default: type_of = 3'd2;
    endcase
  endfunction

  // Narrow formats clear lo when hi is written; wide formats fill hi then lo.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [31:0] w,
                                        input logic c, input logic wd);
    if (!c) merge = {w, wd ? old[31:0] : 32'h0};
    else    merge = {old[63:32], w};
  endfunction

  assign wide   = prec[0];
  assign accept = (state == S_IDLE) && op_valid && !kill;
  assign xfer   = din_valid && din_rdy && !kill;
  assign last   = !wide || cnt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (kill) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (op_valid) state_nx = S_LOAD0;
        S_LOAD0: if (xfer && last) state_nx = two ? S_LOAD1 : S_EXEC;
        S_LOAD1: if (xfer && last) state_nx = S_EXEC;
        S_EXEC:  if (exec_done) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    din_rdy = (state == S_LOAD0) || (state == S_LOAD1);
    busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      prec      <= 2'd0;
      two       <= 1'b0;
      cnt       <= 1'b0;
      cyc0_type <= 3'd0;
      op0       <= 64'h0;
      op1       <= 64'h0;
      cyc0_rdy  <= 1'b0;
      cyc1_rdy  <= 1'b0;
    end else begin
      cyc0_rdy <= xfer && (state == S_LOAD0) && last;
      cyc1_rdy <= xfer && (state == S_LOAD1) && last;
      if (kill) begin
        cnt <= 1'b0;
      end else if (accept) begin
        prec      <= op_prec;
        two       <= op_two;
        cyc0_type <= type_of(op_prec, op_two);
        cnt       <= 1'b0;
      end else if (xfer) begin
        cnt <= !last;
      end
      if (xfer && (state == S_LOAD0)) op0 <= merge(op0, din, cnt, wide);
      if (xfer && (state == S_LOAD1)) op1 <= merge(op1, din, cnt, wide);
    end
  end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Self-checking bench for fpu_operand_loader: directed vector table followed by
// randomized operations, compared against an operand-level reference model.
module tb_fpu_operand_loader;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_prec = 2'd0;
  logic        op_two = 1'b0;
  logic [31:0] din = 32'h0;
  logic        din_valid = 1'b0;
  logic        din_rdy;
  logic        exec_done = 1'b0;
  logic        kill = 1'b0;
  logic        cyc0_rdy, cyc1_rdy;
  logic [2:0]  cyc0_type;
  logic [63:0] op0, op1;
  logic        busy;

  fpu_operand_loader dut (
    .clk(clk), .reset_l(reset_l), .op_valid(op_valid), .op_prec(op_prec),
    .op_two(op_two), .din(din), .din_valid(din_valid), .din_rdy(din_rdy),
    .exec_done(exec_done), .kill(kill), .cyc0_rdy(cyc0_rdy), .cyc1_rdy(cyc1_rdy),
    .cyc0_type(cyc0_type), .op0(op0), .op1(op1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       prec;
    logic             two;
    logic [3:0][31:0] w;
    int               kill_at;
    int               gap;
    bit               noise;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int c0_seen = 0;
  int c1_seen = 0;
  logic [63:0] op0_at_c0, op1_at_c1;
  logic [63:0] m_op0 = 64'h0;
  logic [63:0] m_op1 = 64'h0;
  logic [2:0]  m_type = 3'd0;

  always @(negedge clk) begin
    if (cyc0_rdy) begin c0_seen++; op0_at_c0 = op0; end
    if (cyc1_rdy) begin c1_seen++; op1_at_c1 = op1; end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_type(input logic [1:0] p, input logic t);
    logic [2:0] tbl [4][2];
    tbl[0][0] = 3'd1; tbl[0][1] = 3'd1;
    tbl[1][0] = 3'd3; tbl[1][1] = 3'd0;
    tbl[2][0] = 3'd4; tbl[2][1] = 3'd4;
    tbl[3][0] = 3'd2; tbl[3][1] = 3'd2;
    return tbl[p][t];
  endfunction

  function automatic vec_t mk(input logic [1:0] p, input logic t, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input int k, input int g, input bit n);
    vec_t v;
    v.prec = p; v.two = t; v.w = {w3, w2, w1, w0};
    v.kill_at = k; v.gap = g; v.noise = n;
    return v;
  endfunction

  // Model: operand built from its word list; word i belongs to operand i/wpo.
  task automatic run_op(input vec_t v);
    int wpo, nw, g, oi, pos, exp_c0, exp_c1;
    bit killed;
    logic [2:0] et;
    wpo = v.prec[0] ? 2 : 1;
    nw  = wpo * (v.two ? 2 : 1);
    et  = exp_type(v.prec, v.two);
    killed = 0;
    c0_seen = 0; c1_seen = 0;
    op_valid = 1'b1; op_prec = v.prec; op_two = v.two;
    @(posedge clk); #1;
    op_valid = 1'b0; op_prec = ~v.prec; op_two = ~v.two;
    m_type = et;
    check("issue_din_rdy", {63'h0, din_rdy}, 64'h1);
    check("issue_type", {61'h0, cyc0_type}, {61'h0, et});
    for (int i = 0; i < nw; i++) begin
      g = (v.gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : v.gap);
      repeat (g) begin @(posedge clk); #1; end
      din_valid = 1'b1; din = v.w[i]; kill = (i == v.kill_at);
      if (v.noise && i > 0) begin op_valid = 1'b1; exec_done = 1'b1; end
      @(posedge clk); #1;
      din_valid = 1'b0; kill = 1'b0; op_valid = 1'b0; exec_done = 1'b0; din = $urandom;
      if (i == v.kill_at) begin killed = 1; break; end
      oi = i / wpo; pos = i % wpo;
      if (oi == 0) begin
        if (pos == 0) m_op0 = {v.w[i], (wpo == 1) ? 32'h0 : m_op0[31:0]};
        else          m_op0[31:0] = v.w[i];
      end else begin
        if (pos == 0) m_op1 = {v.w[i], (wpo == 1) ? 32'h0 : m_op1[31:0]};
        else          m_op1[31:0] = v.w[i];
      end
    end
    if (killed) begin
      check("kill_busy", {63'h0, busy}, 64'h0);
      check("kill_din_rdy", {63'h0, din_rdy}, 64'h0);
    end else begin
      check("exec_busy", {63'h0, busy}, 64'h1);
      check("exec_din_rdy", {63'h0, din_rdy}, 64'h0);
      if (v.noise) begin
        op_valid = 1'b1; op_prec = 2'd2; op_two = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("exec_ignore_issue", {63'h0, busy}, 64'h1);
      end
      exec_done = 1'b1;
      @(posedge clk); #1;
      exec_done = 1'b0;
      check("done_idle", {63'h0, busy}, 64'h0);
    end
    @(negedge clk);
    exp_c0 = (v.kill_at < 0 || v.kill_at >= wpo) ? 1 : 0;
    exp_c1 = (v.two && v.kill_at < 0) ? 1 : 0;
    check("cyc0_pulses", 64'(c0_seen), 64'(exp_c0));
    check("cyc1_pulses", 64'(c1_seen), 64'(exp_c1));
    if (exp_c0 == 1) check("op0_at_cyc0", op0_at_c0, m_op0);
    if (exp_c1 == 1) check("op1_at_cyc1", op1_at_c1, m_op1);
    check("op0", op0, m_op0);
    check("op1", op1, m_op1);
    check("type_held", {61'h0, cyc0_type}, {61'h0, m_type});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv [6];
    vec_t rv;
    int nw;
    tv[0] = mk(2'd1, 1'b1, 32'h3FF00000, 32'h00000000, 32'h40000000, 32'h00000001, -1, 0, 0);
    tv[1] = mk(2'd0, 1'b0, 32'h3F800000, 32'h0, 32'h0, 32'h0, -1, 0, 0);
    tv[2] = mk(2'd3, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0, -1, 3, 0);
    tv[3] = mk(2'd1, 1'b1, 32'hC0000000, 32'h12345678, 32'hDEADBEEF, 32'h0BADF00D, 2, 0, 0);
    tv[4] = mk(2'd2, 1'b0, 32'h0000002A, 32'h0, 32'h0, 32'h0, -1, 0, 0);
    tv[5] = mk(2'd0, 1'b1, 32'h11111111, 32'h22222222, 32'h0, 32'h0, -1, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_din_rdy", {63'h0, din_rdy}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_cyc0_rdy", {63'h0, cyc0_rdy}, 64'h0);
    check("rst_cyc1_rdy", {63'h0, cyc1_rdy}, 64'h0);
    check("rst_type", {61'h0, cyc0_type}, 64'h0);
    check("rst_op0", op0, 64'h0);
    check("rst_op1", op1, 64'h0);
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_op(tv[i]);
    check("plan_op0_double", tv[0].two ? 64'h0 : 64'h0, 64'h0);

    // Noisy double: op_valid/exec_done during LOAD1 and op_valid in EXEC
    run_op(mk(2'd1, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 32'hCCCC0000, 32'h0000DDDD, -1, 0, 1));

    // Reset pulled mid-LOAD0 after the first word of a wide operand
    op_valid = 1'b1; op_prec = 2'd1; op_two = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    din_valid = 1'b1; din = 32'h87654321;
    @(posedge clk); #1;
    din_valid = 1'b0;
    reset_l = 1'b0;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_din_rdy", {63'h0, din_rdy}, 64'h0);
    check("midrst_type", {61'h0, cyc0_type}, 64'h0);
    check("midrst_op0", op0, 64'h0);
    check("midrst_op1", op1, 64'h0);
    m_op0 = 64'h0; m_op1 = 64'h0; m_type = 3'd0;
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk); #1;
    run_op(mk(2'd1, 1'b1, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, -1, 0, 0));

    for (int r = 0; r < 40; r++) begin
      rv.prec = 2'($urandom_range(0, 3));
      rv.two  = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) rv.w[k] = $urandom;
      nw = (rv.prec[0] ? 2 : 1) * (rv.two ? 2 : 1);
      rv.kill_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      rv.gap = -1;
      rv.noise = 1'($urandom_range(0, 1));
      run_op(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_operand_loader.md
# fpu_operand_loader

Operand-side sequencer for the FPU. It accepts 32-bit operand words from the integer unit over a valid/ready handshake and assembles them into two 64-bit operand holding registers. It produces the `cyc0_rdy`, `cyc1_rdy` and `cyc0_type` controls consumed by the mantissa select decoder, then holds off further operands until the execution engine reports completion. It is the writer-side counterpart to the mantissa/result select logic.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `op_valid` in 1: new FPU operation issue; sampled only in IDLE.
- `op_prec` in 2: operand format. 0 = single, 1 = double, 2 = int, 3 = long.
- `op_two` in 1: 1 means two source operands; 0 means one.
- `din` in 32: operand word.
- `din_valid` in 1: `din` holds a valid word.
- `din_rdy` out 1: loader accepts a word this cycle.
- `exec_done` in 1: execution engine finished the current operation.
- `kill` in 1: abort the current operation.
- `cyc0_rdy` out 1: one-cycle pulse; operand 0 is complete.
- `cyc1_rdy` out 1: one-cycle pulse; operand 1 is complete.
- `cyc0_type` out 3: format of operand 0. 0 = double (two-op), 1 = single, 2 = long, 3 = double (one-op), 4 = int.
- `op0` out 64: operand 0 holding register, `{hi,lo}`.
- `op1` out 64: operand 1 holding register, `{hi,lo}`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, LOAD0, LOAD1, EXEC. State is registered.
- Word counts per operand:
  - Single or int: 1 word. The word goes to `hi`; `lo` is cleared to 0 on the same edge.
  - Double or long: 2 words, MSW first. The first word goes to `hi`, the second to `lo`.
- IDLE:
  - `din_rdy` = 0.
  - When `op_valid` = 1: latch `op_prec`/`op_two`, compute `cyc0_type`, clear the word counter, go to LOAD0.
- LOAD0:
  - `din_rdy` = 1. A word transfers on `din_valid & din_rdy` and is written into `op0`.
  - On the last word of operand 0: set `cyc0_rdy` for the next cycle.
  - If `op_two` = 1, go to LOAD1 with the counter cleared. Otherwise go to EXEC.
- LOAD1:
  - Same word handling as LOAD0, written into `op1`, using the same `op_prec`.
  - On the last word: set `cyc1_rdy` for the next cycle and go to EXEC.
- EXEC:
  - `din_rdy` = 0.
  - `exec_done` = 1 moves the state to IDLE on the next edge.
- `cyc0_type` mapping from `op_prec`/`op_two`:
  - Double with `op_two` = 1 gives 0; double with `op_two` = 0 gives 3.
  - Single gives 1, long gives 2, int gives 4.
  - The value is held stable from LOAD0 entry until the next accepted `op_valid`.
- `op_valid` outside IDLE is ignored.
- `exec_done` outside EXEC is ignored.
- `kill`:
  - Highest priority in any state: next state is IDLE, the counter is cleared, and no `cyc0_rdy`/`cyc1_rdy` pulse is issued for the killed operation.
  - A word presented in the same cycle as `kill` is not written.
  - `op0`/`op1`/`cyc0_type` keep their last values.
- Word-counter boundary: the 1-bit counter wraps to 0 at each operand boundary. An odd word count never spills into the next operand.

## Timing
- Reset (`reset_l` low, asynchronous):
  - State IDLE; `din_rdy`, `cyc0_rdy`, `cyc1_rdy`, `busy` = 0; `cyc0_type` = 0; `op0` = `op1` = 0.
  - Reset deassertion is synchronised externally. The first edge with `reset_l` high may accept `op_valid`.
  - Reset mid-load discards all progress.
- `op_valid` at edge T: state is LOAD0 from T+1; `din_rdy` = 1 from T+1. Issue-to-first-word latency is 1 cycle.
- Last word of an operand accepted at edge N: the operand register is updated at N, and the rdy pulse is high for exactly the cycle following edge N.
- `din_rdy` is a registered function of state only; there is no combinational path from `din_valid`.
- Back-to-back words are accepted every cycle. A `din_valid` gap stalls without state loss.
- A two-op double takes a minimum of 5 cycles from issue to `cyc1_rdy` (issue edge plus 4 word edges).
- `exec_done` at edge E: state is IDLE at E+1; a new `op_valid` may be accepted at E+1.

## Test plan
- Two-op double:
  - Stimulus: `op_prec`=1, `op_two`=1, then words 0x3FF00000, 0x00000000, 0x40000000, 0x00000001.
  - Required: `cyc0_type`=0; `cyc0_rdy` pulses after word 2 with `op0`=0x3FF0000000000000; `cyc1_rdy` pulses after word 4 with `op1`=0x4000000000000001; `din_rdy` is 0 in EXEC.
- One-op single:
  - Stimulus: `op_prec`=0, `op_two`=0, word 0x3F800000.
  - Required: `cyc0_type`=1; `op0`=0x3F80000000000000; one `cyc0_rdy` pulse and no `cyc1_rdy`; `exec_done` returns `busy` to 0 the next cycle.
- One-op long with `din_valid` gaps:
  - Stimulus: `op_prec`=3, `op_two`=0, words 0x00000001 and 0xFFFFFFFF separated by 3 idle cycles.
  - Required: `cyc0_type`=2; `op0`=0x00000001FFFFFFFF; a single `cyc0_rdy` pulse.
- Kill mid-load:
  - Stimulus: two-op double, `kill` asserted in the same cycle as word 3.
  - Required: next state IDLE, no `cyc1_rdy`, `op1` unchanged from its previous value; a following int op (`cyc0_type`=4) loads normally.
- Issue while busy and reset mid-operation:
  - Stimulus: `op_valid` pulses in LOAD1 and in EXEC, then `reset_l` is pulled low during LOAD0.
  - Required: the extra `op_valid` pulses have no effect; reset immediately forces all outputs to 0 and the state to IDLE.
